// File: rtl/irq_controller.sv
// Eight-source interrupt controller for the 6502 IRQB pin, reached through a
// single-byte command/data register.
module irq_controller #(
   parameter int N_SRC       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cs,
   input  logic             we,
   input  logic             bus_end,
   input  logic [7:0]       data_in,
   output logic [7:0]       data_out,
   input  logic [N_SRC-1:0] irq_in,
   output logic             irqb
);

   typedef enum logic {
      IDLE,
      WAIT_DATA
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       target_q, target_d;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] edgeMode_q, edgeMode_d;
   logic [N_SRC-1:0] sync_q [SYNC_STAGES];
   logic [N_SRC-1:0] sPrev_q;
   logic             irqb_q;
   logic [7:0]       dataOut_q, dataOut_d;

   logic [N_SRC-1:0] s;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] clr;
   logic [N_SRC-1:0] modeChg;
   logic [N_SRC-1:0] edgeNext;
   logic [N_SRC-1:0] active;
   logic [2:0]       idx;
   logic [7:0]       vec;
   logic             commit;

   assign s      = sync_q[SYNC_STAGES-1];
   assign rise   = s & ~sPrev_q;
   assign commit = cs & we & bus_end;
   assign active = pending_q & mask_q;

   // Lowest-numbered active source wins the vector.
   always_comb begin
      idx = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            idx = i[2:0];
         end
      end
      vec = {|active, 4'b0000, idx};
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      target_d   = target_q;
      mask_d     = mask_q;
      edgeMode_d = edgeMode_q;
      clr        = '0;
      case (state_q)
         IDLE: begin
            if (commit) begin
               case (data_in[7:6])
                  2'b00: sel_d = data_in[1:0];
                  2'b01: begin
                     target_d = data_in[1:0];
                     state_d  = WAIT_DATA;
                  end
                  2'b10: clr = N_SRC'(1) << data_in[2:0];
                  default: clr = '1;
               endcase
            end
         end
         WAIT_DATA: begin
            if (commit) begin
               case (target_q)
                  2'd0: clr = data_in;
                  2'd1: mask_d = data_in;
                  2'd2: edgeMode_d = data_in;
                  default: ;
               endcase
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Edge bits hold until cleared, with a fresh edge beating a same-cycle
   // clear; level bits follow the synchronised line, so clears never stick.
   // A bit whose mode is being rewritten restarts from zero.
   always_comb begin
      modeChg   = edgeMode_d ^ edgeMode_q;
      edgeNext  = (pending_q & ~clr) | rise;
      pending_d = ((edgeMode_q & edgeNext) | (~edgeMode_q & s)) & ~modeChg;
   end

   always_comb begin
      dataOut_d = 8'h00;
      if (cs && !we) begin
         case (sel_q)
            2'd0: dataOut_d = pending_q;
            2'd1: dataOut_d = mask_q;
            2'd2: dataOut_d = edgeMode_q;
            default: dataOut_d = vec;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         sPrev_q <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         sPrev_q <= s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= 2'd0;
         target_q   <= 2'd0;
         pending_q  <= '0;
         mask_q     <= '0;
         edgeMode_q <= '0;
         irqb_q     <= 1'b1;
         dataOut_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         target_q   <= target_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         edgeMode_q <= edgeMode_d;
         irqb_q     <= ~|active;
         dataOut_q  <= dataOut_d;
      end
   end

   assign irqb     = irqb_q;
   assign data_out = dataOut_q;

endmodule
